// File: rtl/lbus_if.sv
// Local-bus arbitration signal bundle: master requests and bus handshake in,
// grants, qualified ready and timeout status out.
interface lbus_if #(
  parameter int ERRCNT_W = 8
);
  logic                HOLD0;
  logic                HOLD1;
  logic                EN0;
  logic                EN1;
  logic                ADSn;
  logic                READYn;
  logic                HOLDA0;
  logic                HOLDA1;
  logic                READY_OUTn;
  logic                TIMEOUT_ERR;
  logic                ERR_SRC;
  logic [ERRCNT_W-1:0] ERR_COUNT;

  // Requester/target side of the bus.
  modport master (
    output HOLD0, HOLD1, EN0, EN1, ADSn, READYn,
    input  HOLDA0, HOLDA1, READY_OUTn, TIMEOUT_ERR, ERR_SRC, ERR_COUNT
  );

  // Arbiter side of the bus.
  modport slave (
    input  HOLD0, HOLD1, EN0, EN1, ADSn, READYn,
    output HOLDA0, HOLDA1, READY_OUTn, TIMEOUT_ERR, ERR_SRC, ERR_COUNT
  );
endinterface

// File: rtl/lbus_arbiter.sv
// Two-master round-robin local-bus arbiter with a per-transaction watchdog that
// aborts a stalled cycle by faking READY and logging the offending master.
module lbus_arbiter #(
  parameter int TIMEOUT  = 64,
  parameter int ERRCNT_W = 8
) (
  input logic  CLOCK,
  input logic  RESETn,
  lbus_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT0 = 3'd1,
    GRANT1 = 3'd2,
    ABORT  = 3'd3,
    TURN   = 3'd4
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [7:0]          wd_cnt_q, wd_cnt_d;
  logic                wd_armed_q, wd_armed_d;
  logic                holda0_q, holda0_d;
  logic                holda1_q, holda1_d;
  logic                timeout_err_q, timeout_err_d;
  logic                err_src_q, err_src_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  logic valid0, valid1;
  logic owner;
  logic owner_hold;

  assign valid0     = bus.HOLD0 & bus.EN0;
  assign valid1     = bus.HOLD1 & bus.EN1;
  assign owner      = (state_q == GRANT1);
  assign owner_hold = owner ? bus.HOLD1 : bus.HOLD0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d       = state_q;
    last_d        = last_q;
    wd_cnt_d      = '0;
    wd_armed_d    = 1'b0;
    timeout_err_d = 1'b0;
    err_src_d     = err_src_q;
    err_count_d   = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (valid0 && valid1) state_d = last_q ? GRANT0 : GRANT1;
        else if (valid0)      state_d = GRANT0;
        else if (valid1)      state_d = GRANT1;
      end

      GRANT0, GRANT1: begin
        // Arm on the first strobe; later strobes leave a running count alone.
        wd_armed_d = wd_armed_q | ~bus.ADSn;
        wd_cnt_d   = wd_cnt_q;
        if (wd_armed_d) begin
          if (bus.READYn) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
          end else begin
            wd_cnt_d   = '0;
            wd_armed_d = 1'b0;
          end
        end

        // Timeout takes priority over a simultaneous release of HOLD.
        if (wd_armed_d && (wd_cnt_d == TIMEOUT_C)) begin
          state_d       = ABORT;
          timeout_err_d = 1'b1;
          err_src_d     = owner;
          err_count_d   = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
          wd_cnt_d      = '0;
          wd_armed_d    = 1'b0;
        end else if (!owner_hold) begin
          state_d    = TURN;
          last_d     = owner;
          wd_cnt_d   = '0;
          wd_armed_d = 1'b0;
        end
      end

      ABORT:   state_d = err_src_q ? GRANT1 : GRANT0;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    holda0_d = (state_d == GRANT0) | ((state_d == ABORT) & ~err_src_d);
    holda1_d = (state_d == GRANT1) | ((state_d == ABORT) &  err_src_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      wd_cnt_q      <= '0;
      wd_armed_q    <= 1'b0;
      holda0_q      <= 1'b0;
      holda1_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      err_src_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      wd_cnt_q      <= wd_cnt_d;
      wd_armed_q    <= wd_armed_d;
      holda0_q      <= holda0_d;
      holda1_q      <= holda1_d;
      timeout_err_q <= timeout_err_d;
      err_src_q     <= err_src_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.HOLDA0      = holda0_q;
  assign bus.HOLDA1      = holda1_q;
  assign bus.READY_OUTn  = (state_q == ABORT) ? 1'b0 : bus.READYn;
  assign bus.TIMEOUT_ERR = timeout_err_q;
  assign bus.ERR_SRC     = err_src_q;
  assign bus.ERR_COUNT   = err_count_q;

endmodule

// File: doc/lbus_arbiter.md
LBUS_ARBITER -- requirements
Module: lbus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: number of READYn-high cycles after address strobe before a bus timeout is declared (legal range 2..255).
REQ-002 SHALL have parameter ERRCNT_W, default 8: width of the saturating timeout counter.
REQ-003 CLOCK  input  1  system clock; all state changes on its rising edge.
REQ-004 RESETn  input  1  reset, asynchronous, active-low.
REQ-005 HOLD0  input  1  bus request from master 0 (VME slave local-bus sequencer); level, held for the whole transaction.
REQ-006 HOLD1  input  1  bus request from master 1 (local DMA/housekeeping engine); level.
REQ-007 EN0, EN1  input  1 each  request enables; a request with its enable low is ignored.
REQ-008 ADSn  input  1  local-bus address strobe from the active master, active-low.
REQ-009 READYn  input  1  local-bus target ready, active-low.
REQ-010 HOLDA0, HOLDA1  output  1 each  registered grant to master 0 / master 1.
REQ-011 READY_OUTn  output  1  ready returned to masters: READYn, forced low during a timeout abort.
REQ-012 TIMEOUT_ERR  output  1  one-cycle registered pulse on a bus timeout.
REQ-013 ERR_SRC  output  1  index of the master that last timed out.
REQ-014 ERR_COUNT  output  ERRCNT_W  saturating count of timeouts since reset.

Function
REQ-015 SHALL implement states IDLE, GRANT0, GRANT1, ABORT, TURN; HOLDA0=1 only in GRANT0, HOLDA1=1 only in GRANT1 or ABORT from GRANT1 context (HOLDA0 likewise for ABORT from GRANT0); never both high.
REQ-016 IDLE: valid request = HOLDx & ENx; none -> stay; only one -> GRANTx next edge; both -> grant the master not equal to LAST (round-robin pointer), LAST reset value 1 so master 0 wins first tie.
REQ-017 Grant latency SHALL be exactly one clock: request sampled in IDLE at edge N, HOLDAx high after edge N+1.
REQ-018 GRANTx: stay while HOLDx=1; HOLDx sampled 0 -> TURN, LAST<=x; ENx dropping mid-grant SHALL NOT revoke the grant.
REQ-019 TURN: lasts exactly one cycle with both grants low, then IDLE; minimum gap between grants therefore 2 cycles.
REQ-020 Watchdog counter SHALL clear on entry to GRANTx, arm on the first cycle ADSn is sampled low in GRANTx, increment each armed cycle READYn=1, clear and disarm when READYn sampled 0.
REQ-021 Armed counter reaching TIMEOUT SHALL move GRANTx -> ABORT; ABORT lasts one cycle, keeps HOLDAx high, drives READY_OUTn=0, pulses TIMEOUT_ERR=1, loads ERR_SRC=x, increments ERR_COUNT (saturating at all-ones), then returns to GRANTx with counter cleared and disarmed.
REQ-022 Outside ABORT, READY_OUTn SHALL equal READYn combinationally.
REQ-023 HOLDx dropping in the same cycle the timeout is reached SHALL take ABORT (abort wins), then GRANTx, then TURN on the following sampled HOLDx=0.
REQ-024 A new ADSn low while armed SHALL NOT restart the count.
REQ-025 Requests arriving in TURN SHALL be evaluated only in IDLE.

Reset
REQ-026 RESETn low SHALL force within the same cycle: state IDLE, HOLDA0=HOLDA1=0, TIMEOUT_ERR=0, ERR_SRC=0, ERR_COUNT=0, LAST=1, watchdog cleared and disarmed.
REQ-027 Reset asserted mid-grant or mid-ABORT SHALL drop grants immediately; after release the first grant follows REQ-016/017 with no residual state.

Verification
REQ-028 HOLD0=1,EN0=1 at edge 1 -> HOLDA0=1 after edge 2; HOLD0=0 at edge 10 -> HOLDA0=0 after edge 11, TURN one cycle, IDLE.
REQ-029 HOLD0=HOLD1=1 continuously, each master drops HOLD 3 cycles after its grant -> grants alternate 0,1,0,1, 2-cycle gaps, never overlapping.
REQ-030 TIMEOUT=4, grant 1, ADSn low one cycle, READYn held 1 -> after 4 READYn-high cycles TIMEOUT_ERR=1 for one cycle, READY_OUTn=0 same cycle, ERR_SRC=1, ERR_COUNT=1, HOLDA1 stays high until HOLD1 drops.
REQ-031 ERRCNT_W=2, force 5 timeouts -> ERR_COUNT reads 1,2,3,3,3.
REQ-032 HOLD1=1 with EN1=0 -> no grant; HOLD0 during grant 1 with EN0 toggling -> grant 1 unaffected, master 0 granted after TURN.
REQ-033 RESETn low during armed watchdog count -> all outputs reset values; after release, HOLD0 -> HOLDA0 one cycle later, no TIMEOUT_ERR.
